// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard / forwarding controller.
package hazard_pkg;

  // Shadow rd fields are stored at this width; REG_AW must not exceed it.
  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PCSEL_W    = 2;

  localparam logic [PCSEL_W-1:0] PCSEL_PLUS1 = 2'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_RS    = 2'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_MEM   = 2'd2;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_op;
    logic                  jump_mem;
  } stage_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Three-source operand forwarding selector: EX result, then WB data, then regfile.
module hazard_ctrl_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 6,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic [REG_AW-1:0]     addr_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_to_reg_i,
  input  logic [REG_AW_MAX-1:0] ex_rd_i,
  input  logic                  wb_valid_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_AW_MAX-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]     rf_val_i,
  input  logic [DATA_W-1:0]     ex_alu_i,
  input  logic [DATA_W-1:0]     ex_mem_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [DATA_W-1:0]     val_o
);

  logic [REG_AW_MAX-1:0] addr_ext;
  logic                  zero_pinned;

  assign addr_ext    = REG_AW_MAX'(addr_i);
  assign zero_pinned = (ZERO_REG_EN != 0) && (addr_i == '0);

  // Youngest in-flight writer wins; a pinned r0 always reads the regfile.
  always_comb begin
    val_o = rf_val_i;
    if (!zero_pinned) begin
      if (ex_valid_i && ex_reg_write_i && (ex_rd_i == addr_ext)) begin
        val_o = ex_mem_to_reg_i ? ex_mem_i : ex_alu_i;
      end else if (wb_valid_i && wb_reg_write_i && (wb_rd_i == addr_ext)) begin
        val_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and redirect controller for the IF/ID/EX-MEM/WB pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 6,
  parameter int unsigned MEM_LAT     = 0,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_op,
  input  logic               id_brz,
  input  logic               id_brn,
  input  logic               id_jump,
  input  logic               id_jump_mem,
  input  logic [DATA_W-1:0]  rf_rs_val,
  input  logic [DATA_W-1:0]  rf_rt_val,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [DATA_W-1:0]  ex_mem_data,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_z,
  input  logic               ex_n,
  output logic [DATA_W-1:0]  fwd_rs_val,
  output logic [DATA_W-1:0]  fwd_rt_val,
  output logic [PCSEL_W-1:0] pc_sel,
  output logic               stall_pc,
  output logic               stall_ifid,
  output logic               flush_ifid,
  output logic               bubble_idex,
  output logic               hold_ex,
  output logic               ex_valid_o,
  output logic               wb_valid_o
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  stage_t                ex_q, ex_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_AW_MAX-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  z_q, z_d, n_q, n_d;
  logic                  z_eff, n_eff, br_taken;

  // Operand-use flags are informational only: no load-use interlock needs them.
  logic unused_operand_flags;
  assign unused_operand_flags = id_rs_used ^ id_rt_used;

  // State, counter, shadow stages and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      ex_q           <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      z_q            <= 1'b0;
      n_q            <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_q           <= ex_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      z_q            <= z_d;
      n_q            <= n_d;
    end
  end

  // Memory-latency FSM: a mem op holds EX for MEM_LAT extra cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_ex = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_q.valid && ex_q.mem_op && (MEM_LAT > 0)) begin
          hold_ex = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) begin
          hold_ex = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Flags come live from EX when it holds a real instruction, else from the last one.
  assign z_eff    = ex_q.valid ? ex_z : z_q;
  assign n_eff    = ex_q.valid ? ex_n : n_q;
  assign br_taken = id_valid && id_jump && (!id_brz || z_eff) && (!id_brn || n_eff) && !id_jump_mem;

  // Stall and redirect control; an EX memory-indirect jump outranks any ID branch.
  always_comb begin
    pc_sel      = PCSEL_PLUS1;
    stall_pc    = hold_ex;
    stall_ifid  = hold_ex;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    if (!hold_ex) begin
      if (ex_q.valid && ex_q.jump_mem) begin
        pc_sel      = PCSEL_MEM;
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (br_taken) begin
        pc_sel     = PCSEL_RS;
        flush_ifid = 1'b1;
      end
    end
  end

  // Shadow pipeline advance; a hold freezes EX and drains WB.
  always_comb begin
    ex_d           = ex_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    z_d            = z_q;
    n_d            = n_q;
    if (hold_ex) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d     = ex_q.valid;
      wb_rd_d        = ex_q.rd;
      wb_reg_write_d = ex_q.reg_write;
      if (ex_q.valid) begin
        z_d = ex_z;
        n_d = ex_n;
      end
      ex_d = '0;
      if (id_valid && !bubble_idex) begin
        ex_d.valid      = 1'b1;
        ex_d.rd         = REG_AW_MAX'(id_rd);
        ex_d.reg_write  = id_reg_write;
        ex_d.mem_to_reg = id_mem_to_reg;
        ex_d.mem_op     = id_mem_op;
        ex_d.jump_mem   = id_jump_mem;
      end
    end
  end

  assign ex_valid_o = ex_q.valid;
  assign wb_valid_o = wb_valid_q;

  hazard_ctrl_fwd_sel #(
    .DATA_W      (DATA_W),
    .REG_AW      (REG_AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_fwd_rs (
    .addr_i          (id_rs),
    .ex_valid_i      (ex_q.valid),
    .ex_reg_write_i  (ex_q.reg_write),
    .ex_mem_to_reg_i (ex_q.mem_to_reg),
    .ex_rd_i         (ex_q.rd),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .rf_val_i        (rf_rs_val),
    .ex_alu_i        (ex_alu_result),
    .ex_mem_i        (ex_mem_data),
    .wb_data_i       (wb_data),
    .val_o           (fwd_rs_val)
  );

  hazard_ctrl_fwd_sel #(
    .DATA_W      (DATA_W),
    .REG_AW      (REG_AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_fwd_rt (
    .addr_i          (id_rt),
    .ex_valid_i      (ex_q.valid),
    .ex_reg_write_i  (ex_q.reg_write),
    .ex_mem_to_reg_i (ex_q.mem_to_reg),
    .ex_rd_i         (ex_q.rd),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .rf_val_i        (rf_rt_val),
    .ex_alu_i        (ex_alu_result),
    .ex_mem_i        (ex_mem_data),
    .wb_data_i       (wb_data),
    .val_o           (fwd_rt_val)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus reset / r0 corner sequences.
module tb_hazard_ctrl;

  localparam logic [31:0] RF_RS = 32'hAAAA_0001;
  localparam logic [31:0] RF_RT = 32'hBBBB_0002;
  localparam logic [31:0] ALU   = 32'h0000_0011;
  localparam logic [31:0] MEMD  = 32'h0000_ABCD;
  localparam logic [31:0] WBD   = 32'h0000_0022;

  logic        clk, reset;
  logic        id_valid, id_rs_used, id_rt_used;
  logic [5:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_to_reg, id_mem_op;
  logic        id_brz, id_brn, id_jump, id_jump_mem;
  logic [31:0] rf_rs_val, rf_rt_val, ex_alu_result, ex_mem_data, wb_data;
  logic        ex_z, ex_n;

  logic [31:0] fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b;
  logic [1:0]  pc_sel_a, pc_sel_b;
  logic        stall_pc_a, stall_ifid_a, flush_a, bubble_a, hold_a, exv_a, wbv_a;
  logic        stall_pc_b, stall_ifid_b, flush_b, bubble_b, hold_b, exv_b, wbv_b;
  logic [8:0]  ctrl_a, ctrl_b;

  assign ctrl_a = {pc_sel_a, stall_pc_a, stall_ifid_a, flush_a, bubble_a, hold_a, exv_a, wbv_a};
  assign ctrl_b = {pc_sel_b, stall_pc_b, stall_ifid_b, flush_b, bubble_b, hold_b, exv_b, wbv_b};

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_ctrl #(.DATA_W(32), .REG_AW(6), .MEM_LAT(3), .ZERO_REG_EN(0)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_op(id_mem_op),
    .id_brz(id_brz), .id_brn(id_brn), .id_jump(id_jump), .id_jump_mem(id_jump_mem),
    .rf_rs_val(rf_rs_val), .rf_rt_val(rf_rt_val),
    .ex_alu_result(ex_alu_result), .ex_mem_data(ex_mem_data), .wb_data(wb_data),
    .ex_z(ex_z), .ex_n(ex_n),
    .fwd_rs_val(fwd_rs_a), .fwd_rt_val(fwd_rt_a), .pc_sel(pc_sel_a),
    .stall_pc(stall_pc_a), .stall_ifid(stall_ifid_a), .flush_ifid(flush_a),
    .bubble_idex(bubble_a), .hold_ex(hold_a), .ex_valid_o(exv_a), .wb_valid_o(wbv_a)
  );

  hazard_ctrl #(.DATA_W(32), .REG_AW(6), .MEM_LAT(4), .ZERO_REG_EN(1)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_op(id_mem_op),
    .id_brz(id_brz), .id_brn(id_brn), .id_jump(id_jump), .id_jump_mem(id_jump_mem),
    .rf_rs_val(rf_rs_val), .rf_rt_val(rf_rt_val),
    .ex_alu_result(ex_alu_result), .ex_mem_data(ex_mem_data), .wb_data(wb_data),
    .ex_z(ex_z), .ex_n(ex_n),
    .fwd_rs_val(fwd_rs_b), .fwd_rt_val(fwd_rt_b), .pc_sel(pc_sel_b),
    .stall_pc(stall_pc_b), .stall_ifid(stall_ifid_b), .flush_ifid(flush_b),
    .bubble_idex(bubble_b), .hold_ex(hold_b), .ex_valid_o(exv_b), .wb_valid_o(wbv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       idv;
    logic [5:0] rs, rt, rd;
    logic       rw, m2r, mop, brz, brn, jmp, jm, ez, en;
    logic [31:0] e_rs, e_rt;
    logic [1:0] e_pcs;
    logic       e_stall, e_flush, e_bub, e_hold, e_exv, e_wbv;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Control bits are {pc_sel, stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_ex, ex_valid_o, wb_valid_o}.
  task automatic chk_ctrl(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                        input logic rw, input logic m2r, input logic mop, input logic brz,
                        input logic brn, input logic jmp, input logic jm);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_mem_to_reg = m2r; id_mem_op = mop;
    id_brz = brz; id_brn = brn; id_jump = jmp; id_jump_mem = jm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rf_rs_val = RF_RS; rf_rt_val = RF_RT;
    ex_alu_result = ALU; ex_mem_data = MEMD; wb_data = WBD;
    ex_z = 1'b0; ex_n = 1'b0;

    // Reset state.
    #2;
    chk_ctrl("reset.ctrl_a", ctrl_a, 9'b0);
    chk_ctrl("reset.ctrl_b", ctrl_b, 9'b0);
    chk("reset.fwd_rs_a", fwd_rs_a, RF_RS);
    next_cycle();
    reset = 1'b1;

    //            idv rs rt rd rw m2r mop brz brn jmp jm ez en  e_rs   e_rt   pcs st fl bu ho exv wbv
    vecs[0]  = '{1, 5, 6, 5, 1, 0, 0,  0, 0, 0, 0,  0, 0, RF_RS, RF_RT, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 5, 9, 5, 1, 0, 0,  0, 0, 0, 0,  1, 0, ALU,   RF_RT, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 5, 5, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, ALU,   ALU,   0, 0, 0, 0, 0, 1, 1};
    vecs[3]  = '{0, 5, 7, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, WBD,   RF_RT, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 3, 4, 0, 0, 0, 0,  1, 0, 1, 0,  0, 0, RF_RS, RF_RT, 1, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{1, 3, 4, 0, 0, 0, 0,  1, 0, 1, 0,  0, 0, RF_RS, RF_RT, 0, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{1, 3, 4, 0, 0, 0, 0,  0, 0, 1, 1,  0, 0, RF_RS, RF_RT, 0, 0, 0, 0, 0, 1, 1};
    vecs[7]  = '{1, 3, 4, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, RF_RS, RF_RT, 2, 0, 1, 1, 0, 1, 1};
    vecs[8]  = '{1, 2, 4, 7, 1, 1, 1,  0, 0, 0, 0,  0, 0, RF_RS, RF_RT, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, MEMD,  RF_RT, 0, 1, 0, 0, 1, 1, 0};
    vecs[10] = '{1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, MEMD,  RF_RT, 0, 1, 0, 0, 1, 1, 0};
    vecs[11] = '{1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, MEMD,  RF_RT, 0, 1, 0, 0, 1, 1, 0};
    vecs[12] = '{1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0,  0, 0, MEMD,  RF_RT, 0, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 7, 8, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, WBD,   ALU,   0, 0, 0, 0, 0, 1, 1};
    vecs[14] = '{1, 3, 4, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0, RF_RS, RF_RT, 1, 0, 1, 0, 0, 0, 1};
    vecs[15] = '{1, 3, 4, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0, RF_RS, RF_RT, 0, 0, 0, 0, 0, 1, 0};

    for (int i = 0; i < 16; i++) begin
      set_id(vecs[i].idv, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rw, vecs[i].m2r,
             vecs[i].mop, vecs[i].brz, vecs[i].brn, vecs[i].jmp, vecs[i].jm);
      ex_z = vecs[i].ez;
      ex_n = vecs[i].en;
      #2;
      chk($sformatf("v%0d.fwd_rs", i), fwd_rs_a, vecs[i].e_rs);
      chk($sformatf("v%0d.fwd_rt", i), fwd_rt_a, vecs[i].e_rt);
      chk_ctrl($sformatf("v%0d.ctrl", i), ctrl_a,
               {vecs[i].e_pcs, vecs[i].e_stall, vecs[i].e_stall, vecs[i].e_flush,
                vecs[i].e_bub, vecs[i].e_hold, vecs[i].e_exv, vecs[i].e_wbv});
      next_cycle();
    end

    // r0 forwarding: only the ZERO_REG_EN instance must ignore the in-flight write.
    ex_z = 1'b0; ex_n = 1'b0;
    reset_pulse();
    ex_alu_result = 32'h55;
    set_id(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    set_id(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("zero.fwd_rt_a", fwd_rt_a, 32'h55);
    chk("zero.fwd_rt_b", fwd_rt_b, RF_RT);
    ex_alu_result = ALU;

    // Reset dropped two cycles into a MEM_LAT=4 hold.
    next_cycle();
    reset_pulse();
    set_id(1, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0);
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_ctrl("memwait.h1_b", ctrl_b, 9'b00_1_1_0_0_1_1_0);
    next_cycle();
    #2;
    chk_ctrl("memwait.h2_b", ctrl_b, 9'b00_1_1_0_0_1_1_0);
    reset = 1'b0;
    #1;
    chk_ctrl("memwait.rst_b", ctrl_b, 9'b0);
    chk_ctrl("memwait.rst_a", ctrl_a, 9'b0);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk_ctrl($sformatf("memwait.post%0d_b", k), ctrl_b, 9'b0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard, forwarding and redirect controller for the next-generation IF / ID / EX-MEM / WB pipeline.
- Tracks in-flight destinations in shadow valid/control registers.
- Forwards EX/WB results to ID operands.
- Holds the pipe for multi-cycle memory ops.
- Resolves ID branches and EX memory-indirect jumps, flushing or bubbling wrong-path instructions. Previously the datapath had no interlocks.

Parameters:
- DATA_W, 32, datapath/operand width
- REG_AW, 6, register address width
- MEM_LAT, 0, extra cycles a memory op occupies EX (0..15)
- ZERO_REG_EN, 0, 1 = register 0 never forwarded (reads regfile value)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  ID register fields
- id_rs_used, id_rt_used  in  1  operand consumed
- id_reg_write, id_mem_to_reg, id_mem_op  in  1  ID control (mem_op = MemRead|MemWrite)
- id_brz, id_brn, id_jump, id_jump_mem  in  1  ID branch control
- rf_rs_val, rf_rt_val  in  DATA_W  regfile reads
- ex_alu_result, ex_mem_data, wb_data  in  DATA_W  forwarding sources
- ex_z, ex_n  in  1  live ALU flags
- fwd_rs_val, fwd_rt_val  out  DATA_W  forwarded operands
- pc_sel  out  2  0 = pc+1, 1 = fwd_rs_val, 2 = data memory
- stall_pc, stall_ifid  out  1  hold PC / IF-ID
- flush_ifid  out  1  IF-ID loads bubble
- bubble_idex  out  1  ID-EX loads bubble
- hold_ex  out  1  hold ID-EX, EX-WB loads bubble
- ex_valid_o, wb_valid_o  out  1  shadow valids (gate MemWrite/RegWrite)

Behaviour:
- Reset (async, reset=0):
  - state=RUN, cnt=0.
  - All shadow valids=0; flag regs z_q=n_q=0.
  - All control outputs 0; pc_sel=0.
  - Applies immediately, including mid-MEM_WAIT; release resumes in RUN.
- Shadow registers:
  - EX: valid, rd, reg_write, mem_to_reg, mem_op, jump_mem.
  - WB: valid, rd, reg_write.
- Per-cycle shadow update:
  - hold_ex=1: EX keeps its contents, WB.valid<=0.
  - Otherwise: EX <= (bubble_idex | !id_valid) ? invalid : ID fields; WB <= EX.
- Flag registers: z_q/n_q <= ex_z/ex_n whenever EX.valid and !hold_ex.
- Effective flags: live ex flags if EX.valid, else z_q/n_q.
- FSM:
  - RUN: hold_ex = EX.valid & EX.mem_op & (MEM_LAT>0). If asserted, go to MEM_WAIT with cnt<=MEM_LAT-1.
  - MEM_WAIT: hold_ex = (cnt!=0); cnt decrements; at cnt==0, hold_ex=0 and return to RUN.
  - A memory op therefore occupies EX for exactly MEM_LAT+1 cycles.
  - Back-to-back mem ops re-enter MEM_WAIT directly.
- hold_ex=1 forces:
  - stall_pc=stall_ifid=1.
  - No redirect; flush_ifid=bubble_idex=0.
- Forwarding (combinational, per operand; first match wins):
  1. EX.valid & EX.reg_write & rd==addr: ex_mem_data if EX.mem_to_reg, else ex_alu_result.
  2. WB.valid & WB.reg_write & rd==addr: wb_data.
  3. Otherwise the rf value.
  - With ZERO_REG_EN=1 and addr==0, always the rf value.
  - Forwarding of an EX load is only legal when hold_ex=0. During a hold the front end is stalled, so no extra load-use stall is required.
- Redirect priority, applied only when !hold_ex:
  1. EX jump_mem (EX.valid & EX.jump_mem): pc_sel=2, flush_ifid=1, bubble_idex=1. Any ID redirect is suppressed.
  2. ID branch taken = id_valid & id_jump & (!id_brz | Zeff) & (!id_brn | Neff) & !id_jump_mem: pc_sel=1, flush_ifid=1.
  3. Otherwise pc_sel=0.
- An ID jump_mem never redirects in ID; it redirects one cycle later from EX.
- Outputs: all combinational from state + inputs, except ex_valid_o/wb_valid_o, which are registered.

Decomposition:
- Shared package hazard_pkg:
  - pc_sel encodings PCSEL_PLUS1 / PCSEL_RS / PCSEL_MEM.
  - State enum {RUN, MEM_WAIT}.
  - Shadow-stage struct (valid, rd, reg_write, mem_to_reg, mem_op, jump_mem).
- One natural sub-module: fwd_sel, the combinational three-source forwarding selector. It is instantiated twice, for rs and rt.

Test Plan:
- Forwarding priority: EX writes r5 (alu=0x11), WB writes r5 (wb=0x22), ID reads rs=5 → fwd_rs_val=0x11. Next cycle with a bubble entering EX → fwd_rs_val=0x22.
- Multi-cycle memory op: MEM_LAT=3, load r7 in EX → hold_ex/stall_pc high exactly 3 cycles, wb_valid_o=0 during the hold. Fourth cycle: hold_ex=0 and ID rs=7 gets ex_mem_data=0xABCD.
- Flag-dependent branch: id_jump=1, id_brz=1.
  - EX bubble with z_q=1 → pc_sel=1, flush_ifid=1.
  - Repeat with ex_valid and ex_z=0 → pc_sel=0.
- Memory-indirect jump: jump_mem reaches EX while a branch-taken instruction sits in ID → pc_sel=2, flush_ifid=1, bubble_idex=1. Next cycle ex_valid_o=0.
- Reset mid-MEM_WAIT: MEM_LAT=4, drop reset 2 cycles into the hold → all outputs 0 immediately. After release, state=RUN with no residual hold.
- ZERO_REG_EN=1: EX writes r0=0x55, ID reads rt=0 → fwd_rt_val=rf_rt_val.
